// File: rtl/multibuffer_queue_pkg.sv
// Shared constants for the width-converting multibuffer queue: default geometry,
// derived widths and the read-arming saturation value.
package multibuffer_queue_pkg;

    localparam int MBQ_Q_DATA_WIDTH      = 128;
    localparam int MBQ_DATA_OUT_WIDTH    = 64;
    localparam int MBQ_M_BUFF_NUM        = 4;
    localparam int MBQ_M_BUFF_ADDR_WIDTH = 10;
    localparam int MBQ_INFO_WIDTH        = 10;
    localparam int MBQ_ADDR_WIDTH        = 32;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

    localparam int MBQ_R      = MBQ_Q_DATA_WIDTH / MBQ_DATA_OUT_WIDTH;
    localparam int MBQ_DEPTH  = 1 << MBQ_M_BUFF_ADDR_WIDTH;
    localparam int MBQ_CAP    = MBQ_M_BUFF_NUM * MBQ_DEPTH;
    localparam int MBQ_CHK_W  = clog2_min1(MBQ_R);
    localparam int MBQ_BSEL_W = clog2_min1(MBQ_M_BUFF_NUM);
    localparam int MBQ_WCNT_W = clog2_min1(MBQ_CAP + 1);
    localparam int MBQ_CCNT_W = clog2_min1(MBQ_CAP * MBQ_R + 1);

    localparam logic [1:0] ARM_SAT = 2'd2;

endpackage

// File: rtl/mbq_ram_bank.sv
// One storage bank: simple dual-port synchronous RAM with registered read data.
module mbq_ram_bank #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/multibuffer_queue.sv
// Wide-in / narrow-out FIFO over interleaved RAM banks. A small prefetch queue in
// front of the banks keeps pops bubble-free and gives one-cycle write-to-read latency.
module multibuffer_queue
    import multibuffer_queue_pkg::*;
#(
    parameter int Q_DATA_WIDTH      = MBQ_Q_DATA_WIDTH,
    parameter int DATA_OUT_WIDTH    = MBQ_DATA_OUT_WIDTH,
    parameter int M_BUFF_NUM        = MBQ_M_BUFF_NUM,
    parameter int M_BUFF_ADDR_WIDTH = MBQ_M_BUFF_ADDR_WIDTH,
    parameter int INFO_WIDTH        = MBQ_INFO_WIDTH,
    parameter int ADDR_WIDTH        = MBQ_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_en,
    input  logic [Q_DATA_WIDTH-1:0]   data_in,
    output logic                      waitrequest,
    input  logic                      read_en,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      data_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full
);

    localparam int R        = Q_DATA_WIDTH / DATA_OUT_WIDTH;
    localparam int DEPTH    = 1 << M_BUFF_ADDR_WIDTH;
    localparam int CAP      = M_BUFF_NUM * DEPTH;
    localparam int WPTR_W   = clog2_min1(CAP) + 1;
    localparam int BSEL_W   = clog2_min1(M_BUFF_NUM);
    localparam int CHK_W    = clog2_min1(R);
    localparam int WCNT_W   = clog2_min1(CAP + 1);
    localparam int CCNT_W   = clog2_min1(CAP * R + 1);
    localparam int PF_DEPTH = 3;

    if (Q_DATA_WIDTH % DATA_OUT_WIDTH != 0 || INFO_WIDTH < 0 || ADDR_WIDTH < 0) begin : g_bad_cfg
        $error("multibuffer_queue: Q_DATA_WIDTH must be a multiple of DATA_OUT_WIDTH");
    end

    logic [WPTR_W-1:0]   wr_ptr, fetch_ptr;
    logic [WCNT_W-1:0]   word_cnt;
    logic [CCNT_W-1:0]   chunk_cnt;
    logic [CHK_W-1:0]    chk_idx;
    logic [1:0]          arm;
    logic [PF_DEPTH-1:0][Q_DATA_WIDTH-1:0] pf, pf_nxt;
    logic [1:0]          pf_cnt, pf_cnt_nxt;
    logic                rd_vld;
    logic [BSEL_W-1:0]   rd_bank;
    logic [M_BUFF_NUM-1:0][Q_DATA_WIDTH-1:0] bank_rdata;

    logic [BSEL_W-1:0]            wr_bank, fetch_bank;
    logic [M_BUFF_ADDR_WIDTH-1:0] wr_addr, fetch_addr;
    logic                         wr_acc, pop, consume, unfetched, pf_room, issue, bypass;
    logic [2:0]                   pf_occ;
    logic [Q_DATA_WIDTH-1:0]      rd_data;

    assign full        = (word_cnt == WCNT_W'(CAP));
    assign empty       = (chunk_cnt == '0);
    assign almost_full = (word_cnt >= WCNT_W'(CAP - M_BUFF_NUM));
    assign waitrequest = full;

    assign wr_acc  = write_en && !full;
    assign pop     = read_en && (arm == ARM_SAT) && !empty;
    assign consume = pop && (chk_idx == CHK_W'(R - 1));

    assign wr_bank    = BSEL_W'(wr_ptr % WPTR_W'(M_BUFF_NUM));
    assign wr_addr    = M_BUFF_ADDR_WIDTH'(wr_ptr / WPTR_W'(M_BUFF_NUM));
    assign fetch_bank = BSEL_W'(fetch_ptr % WPTR_W'(M_BUFF_NUM));
    assign fetch_addr = M_BUFF_ADDR_WIDTH'(fetch_ptr / WPTR_W'(M_BUFF_NUM));

    // Prefetch entries plus the in-flight RAM read never exceed PF_DEPTH words.
    assign pf_occ    = {1'b0, pf_cnt} + {2'b0, rd_vld} - {2'b0, consume};
    assign pf_room   = (pf_occ < 3'(PF_DEPTH));
    assign unfetched = (wr_ptr != fetch_ptr);
    assign issue     = unfetched && pf_room;
    // When every stored word is already prefetched, a new word skips the RAM.
    assign bypass    = wr_acc && !unfetched && pf_room;
    assign rd_data   = bank_rdata[rd_bank];

    for (genvar g = 0; g < M_BUFF_NUM; g++) begin : g_bank
        mbq_ram_bank #(
            .DATA_WIDTH(Q_DATA_WIDTH),
            .ADDR_WIDTH(M_BUFF_ADDR_WIDTH)
        ) u_bank (
            .clk  (clk),
            .we   (wr_acc && (wr_bank == BSEL_W'(g))),
            .waddr(wr_addr),
            .wdata(data_in),
            .re   (issue && (fetch_bank == BSEL_W'(g))),
            .raddr(fetch_addr),
            .rdata(bank_rdata[g])
        );
    end

    // Older in-flight RAM data lands ahead of a same-cycle bypassed word.
    always_comb begin
        pf_nxt     = pf;
        pf_cnt_nxt = pf_cnt;
        if (consume) begin
            for (int i = 0; i < PF_DEPTH - 1; i++) pf_nxt[i] = pf[i+1];
            pf_cnt_nxt = pf_cnt - 2'd1;
        end
        if (rd_vld) begin
            pf_nxt[pf_cnt_nxt] = rd_data;
            pf_cnt_nxt         = pf_cnt_nxt + 2'd1;
        end
        if (bypass) begin
            pf_nxt[pf_cnt_nxt] = data_in;
            pf_cnt_nxt         = pf_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            fetch_ptr  <= '0;
            word_cnt   <= '0;
            chunk_cnt  <= '0;
            chk_idx    <= '0;
            arm        <= '0;
            pf         <= '0;
            pf_cnt     <= '0;
            rd_vld     <= 1'b0;
            rd_bank    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            pf        <= pf_nxt;
            pf_cnt    <= pf_cnt_nxt;
            rd_vld    <= issue;
            if (issue) rd_bank <= fetch_bank;
            if (issue || bypass) fetch_ptr <= fetch_ptr + WPTR_W'(1);
            if (wr_acc) wr_ptr <= wr_ptr + WPTR_W'(1);
            word_cnt  <= word_cnt + WCNT_W'(wr_acc) - WCNT_W'(consume);
            chunk_cnt <= chunk_cnt + (wr_acc ? CCNT_W'(R) : '0) - CCNT_W'(pop);
            arm       <= !read_en ? 2'd0 : (arm == ARM_SAT) ? ARM_SAT : arm + 2'd1;
            data_valid <= pop;
            if (pop) begin
                data_out <= pf[0][chk_idx*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
                chk_idx  <= consume ? '0 : chk_idx + CHK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multibuffer_queue.sv
// Randomized bench for multibuffer_queue checked cycle by cycle against a
// chunk-queue reference model.
`timescale 1ns/1ps
module tb_multibuffer_queue;
    import multibuffer_queue_pkg::*;

    localparam int QW  = MBQ_Q_DATA_WIDTH;
    localparam int D   = MBQ_DATA_OUT_WIDTH;
    localparam int R   = MBQ_R;
    localparam int M   = MBQ_M_BUFF_NUM;
    localparam int CAP = MBQ_CAP;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [QW-1:0] data_in = '0;
    logic          waitrequest, data_valid, full, empty, almost_full;
    logic [D-1:0]  data_out;

    always #5 clk = ~clk;

    multibuffer_queue #(
        .Q_DATA_WIDTH(QW), .DATA_OUT_WIDTH(D), .M_BUFF_NUM(M),
        .M_BUFF_ADDR_WIDTH(MBQ_M_BUFF_ADDR_WIDTH), .INFO_WIDTH(MBQ_INFO_WIDTH),
        .ADDR_WIDTH(MBQ_ADDR_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in),
        .waitrequest(waitrequest), .read_en(read_en), .data_out(data_out),
        .data_valid(data_valid), .full(full), .empty(empty), .almost_full(almost_full)
    );

    int total = 0;
    int bad   = 0;

    // reference model: queue of unread chunks plus the read_en streak length
    logic [D-1:0] mq[$];
    int           streak = 0;
    logic [D-1:0] exp_dout = '0;
    logic         exp_valid = 1'b0;
    bit           last_acc = 1'b0;
    int           pops = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int words_held();
        return (mq.size() + R - 1) / R;
    endfunction

    function automatic logic [QW-1:0] mkword(input int base);
        logic [QW-1:0] w;
        for (int j = 0; j < R; j++) w[j*D +: D] = D'(base * R + j);
        return w;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "/valid"}, 64'(data_valid), 64'(exp_valid));
        chk({tag, "/dout"},  64'(data_out),   64'(exp_dout));
        chk({tag, "/empty"}, 64'(empty),      64'(mq.size() == 0));
        chk({tag, "/full"},  64'(full),       64'(words_held() == CAP));
        chk({tag, "/afull"}, 64'(almost_full), 64'(words_held() >= CAP - M));
        chk({tag, "/wreq"},  64'(waitrequest), 64'(words_held() == CAP));
    endtask

    task automatic tick(input string tag);
        bit pop;
        @(posedge clk);
        last_acc  = write_en && (words_held() != CAP);
        pop       = read_en && streak >= 2 && mq.size() > 0;
        exp_valid = pop;
        if (pop) exp_dout = mq.pop_front();
        if (last_acc) for (int j = 0; j < R; j++) mq.push_back(data_in[j*D +: D]);
        streak = read_en ? streak + 1 : 0;
        #1;
        check_outputs(tag);
        if (data_valid) pops++;
    endtask

    task automatic model_reset();
        mq.delete();
        streak    = 0;
        exp_dout  = '0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        write_en = 1'b0;
        read_en  = 1'b0;
        rst      = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] vals[32];
        int p0, sent, c;

        // reset and idle
        do_reset();
        repeat (4) tick("idle");

        // 16 random words, continuous read
        for (int i = 0; i < 32; i++) vals[i] = {$urandom, $urandom};
        for (int i = 0; i < 32 / R; i++) begin
            write_en = 1'b1;
            for (int j = 0; j < R; j++) data_in[j*D +: D] = vals[i*R + j];
            tick("wr16");
        end
        write_en = 1'b0;
        read_en  = 1'b1;
        p0 = pops;
        repeat (36) tick("rd16");
        read_en = 1'b0;
        chk("rd16_count", 64'(pops - p0), 64'd32);
        tick("rd16_end");

        // short pulses pop nothing, then 3-cycle bursts pop one each
        for (int i = 0; i < 32 / R; i++) begin
            write_en = 1'b1;
            data_in  = mkword(i);
            tick("wr_pulse");
        end
        write_en = 1'b0;
        p0 = pops;
        for (int i = 0; i < 32; i++) begin
            read_en = 1'b1; tick("pulse_hi");
            read_en = 1'b0; tick("pulse_lo");
        end
        chk("pulse_count", 64'(pops - p0), 64'd0);
        p0 = pops;
        for (int i = 0; i < 32; i++) begin
            read_en = 1'b1;
            repeat (3) tick("burst_hi");
            read_en = 1'b0;
            tick("burst_lo");
        end
        chk("burst_count", 64'(pops - p0), 64'd32);

        // fill to capacity, dropped writes, full drain
        sent = 0;
        while (!waitrequest && sent < CAP + 8) begin
            write_en = 1'b1;
            data_in  = mkword(sent);
            tick("fill");
            if (last_acc) sent++;
        end
        chk("fill_words", 64'(sent), 64'(CAP));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_afull", 64'(almost_full), 64'd1);
        for (int i = 0; i < 4; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            tick("drop");
        end
        write_en = 1'b0;
        read_en  = 1'b1;
        p0 = pops;
        repeat (CAP * R + 4) tick("drain");
        read_en = 1'b0;
        chk("drain_count", 64'(pops - p0), 64'(CAP * R));
        chk("drain_empty", 64'(empty), 64'd1);

        // concurrent writer and late-starting reader
        sent = 0;
        c    = 0;
        p0   = pops;
        while ((sent < 1024 || mq.size() > 0) && c < 6000) begin
            write_en = (sent < 1024);
            data_in  = mkword(sent);
            read_en  = (c >= 110);
            tick("conc");
            if (last_acc) sent++;
            c++;
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        chk("conc_bound", 64'(c < 6000), 64'd1);
        chk("conc_sent", 64'(sent), 64'd1024);
        chk("conc_count", 64'(pops - p0), 64'(1024 * R));
        tick("conc_end");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            write_en = 1'($urandom_range(0, 1));
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 5) == 0) read_en = ~read_en;
            tick("rand");
        end
        write_en = 1'b0;
        read_en  = 1'b1;
        c = 0;
        while (mq.size() > 0 && c < 10000) begin
            tick("rand_drain");
            c++;
        end
        read_en = 1'b0;
        chk("rand_drain_bound", 64'(c < 10000), 64'd1);
        tick("rand_end");

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 8; i++) begin
            write_en = 1'b1;
            data_in  = mkword(100 + i);
            tick("wr_mid");
        end
        write_en = 1'b0;
        read_en  = 1'b1;
        repeat (5) tick("rd_mid");
        chk("mid_active", 64'(data_valid), 64'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("mid_reset");
        read_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick("post_reset");
        chk("post_reset_empty", 64'(empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
